dec_pipe_stage: RTL and testbench

//  Registered, handshaked MIPS-subset decode stage; successor of the combinational decoder.

---
 rtl/dec_pipe_stage_pkg.sv | 100 ++++++++++
 rtl/dec_pipe_stage_core.sv | 130 +++++++++++++
 rtl/dec_pipe_stage.sv | 158 +++++++++++++++
 tb/tb_dec_pipe_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_pipe_stage_pkg.sv
// Shared encodings for the registered MIPS-subset decode stage: opcodes, functs,
// control-field encodings, the decoded control bundle and the hazard FSM states.
package dec_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [3:0] AF_ADD  = 4'd0;
    localparam logic [3:0] AF_SUB  = 4'd1;
    localparam logic [3:0] AF_AND  = 4'd2;
    localparam logic [3:0] AF_OR   = 4'd3;
    localparam logic [3:0] AF_XOR  = 4'd4;
    localparam logic [3:0] AF_NOR  = 4'd5;
    localparam logic [3:0] AF_SLT  = 4'd6;
    localparam logic [3:0] AF_SLTU = 4'd7;
    localparam logic [3:0] AF_LUI  = 4'd8;

    localparam logic [3:0] BF_NONE = 4'd0;
    localparam logic [3:0] BF_EQ   = 4'd1;
    localparam logic [3:0] BF_NE   = 4'd2;
    localparam logic [3:0] BF_LEZ  = 4'd3;
    localparam logic [3:0] BF_GTZ  = 4'd4;

    localparam logic [2:0] SH_NONE = 3'd0;
    localparam logic [2:0] SH_SLL  = 3'd1;
    localparam logic [2:0] SH_SRL  = 3'd2;
    localparam logic [2:0] SH_SRA  = 3'd3;
    localparam logic [2:0] SH_SLLV = 3'd5;
    localparam logic [2:0] SH_SRLV = 3'd6;
    localparam logic [2:0] SH_SRAV = 3'd7;

    localparam logic [1:0] GP_MUX_ALU = 2'b00;
    localparam logic [1:0] GP_MUX_DM  = 2'b01;
    localparam logic [1:0] GP_MUX_PC4 = 2'b10;

    localparam logic [1:0] PC_MUX_PC4  = 2'b00;
    localparam logic [1:0] PC_MUX_BR   = 2'b01;
    localparam logic [1:0] PC_MUX_JUMP = 2'b10;
    localparam logic [1:0] PC_MUX_REG  = 2'b11;

    typedef enum logic [1:0] {
        HZ_IDLE   = 2'd0,
        HZ_LD_OUT = 2'd1,
        HZ_LD_GAP = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic [3:0] af;
        logic       immSext;
        logic       aluBImm;
        logic       gpWe;
        logic [1:0] gpMux;
        logic [3:0] bf;
        logic       dmWe;
        logic [2:0] shift;
        logic [1:0] pcMux;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Only the constant shifts legitimately carry a non-zero shamt field.
    function automatic logic shamtAllowed(input logic [5:0] fn);
        return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
    endfunction

endpackage

// File: rtl/dec_pipe_stage_core.sv
// Purely combinational MIPS-subset decoder: instruction word in, control bundle,
// write address, illegal flag and hazard hints (reads_rt, is_load) out.
module dec_core
    import dec_pkg::*;
#(
    parameter int RAW      = 5,
    parameter int LINK_REG = 31
) (
    input  logic [31:0]    i_instruction,
    output ctrl_t          o_ctrl,
    output logic [RAW-1:0] o_cad,
    output logic           o_illegal,
    output logic           o_readsRt,
    output logic           o_isLoad
);

    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic [4:0] w_shamt;
    logic       w_illegal;

    assign w_op    = i_instruction[31:26];
    assign w_rt    = i_instruction[20:16];
    assign w_rd    = i_instruction[15:11];
    assign w_shamt = i_instruction[10:6];
    assign w_fn    = i_instruction[5:0];

    assign o_isLoad  = (w_op == OP_LW);
    assign o_readsRt = (w_op == OP_RTYPE) || (w_op == OP_SW) ||
                       (w_op == OP_BEQ)   || (w_op == OP_BNE);
    assign o_illegal = w_illegal;

    always_comb begin
        o_ctrl    = CTRL_NOP;
        o_cad     = '0;
        w_illegal = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                o_cad        = RAW'(w_rd);
                o_ctrl.gpWe  = 1'b1;
                case (w_fn)
                    FN_ADD, FN_ADDU: o_ctrl.af    = AF_ADD;
                    FN_SUB, FN_SUBU: o_ctrl.af    = AF_SUB;
                    FN_AND:          o_ctrl.af    = AF_AND;
                    FN_OR:           o_ctrl.af    = AF_OR;
                    FN_XOR:          o_ctrl.af    = AF_XOR;
                    FN_NOR:          o_ctrl.af    = AF_NOR;
                    FN_SLT:          o_ctrl.af    = AF_SLT;
                    FN_SLTU:         o_ctrl.af    = AF_SLTU;
                    FN_SLL:          o_ctrl.shift = SH_SLL;
                    FN_SRL:          o_ctrl.shift = SH_SRL;
                    FN_SRA:          o_ctrl.shift = SH_SRA;
                    FN_SLLV:         o_ctrl.shift = SH_SLLV;
                    FN_SRLV:         o_ctrl.shift = SH_SRLV;
                    FN_SRAV:         o_ctrl.shift = SH_SRAV;
                    FN_JR: begin
                        o_ctrl.gpWe  = 1'b0;
                        o_cad        = '0;
                        o_ctrl.pcMux = PC_MUX_REG;
                    end
                    FN_JALR: begin
                        o_cad        = RAW'(LINK_REG);
                        o_ctrl.gpMux = GP_MUX_PC4;
                        o_ctrl.pcMux = PC_MUX_REG;
                    end
                    default: w_illegal = 1'b1;
                endcase
                if ((w_shamt != 5'd0) && !shamtAllowed(w_fn)) begin
                    w_illegal = 1'b1;
                end
            end
            OP_J: o_ctrl.pcMux = PC_MUX_JUMP;
            OP_JAL: begin
                o_cad        = RAW'(LINK_REG);
                o_ctrl.gpWe  = 1'b1;
                o_ctrl.gpMux = GP_MUX_PC4;
                o_ctrl.pcMux = PC_MUX_JUMP;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                o_ctrl.af      = AF_SUB;
                o_ctrl.immSext = 1'b1;
                o_ctrl.pcMux   = PC_MUX_BR;
                case (w_op)
                    OP_BEQ:  o_ctrl.bf = BF_EQ;
                    OP_BNE:  o_ctrl.bf = BF_NE;
                    OP_BLEZ: o_ctrl.bf = BF_LEZ;
                    default: o_ctrl.bf = BF_GTZ;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                o_cad          = RAW'(w_rt);
                o_ctrl.gpWe    = 1'b1;
                o_ctrl.aluBImm = 1'b1;
                // Logical immediates and LUI zero-extend; arithmetic ones sign-extend.
                case (w_op)
                    OP_ADDI, OP_ADDIU: begin o_ctrl.af = AF_ADD;  o_ctrl.immSext = 1'b1; end
                    OP_SLTI:           begin o_ctrl.af = AF_SLT;  o_ctrl.immSext = 1'b1; end
                    OP_SLTIU:          begin o_ctrl.af = AF_SLTU; o_ctrl.immSext = 1'b1; end
                    OP_ANDI:           o_ctrl.af = AF_AND;
                    OP_ORI:            o_ctrl.af = AF_OR;
                    OP_XORI:           o_ctrl.af = AF_XOR;
                    default:           o_ctrl.af = AF_LUI;
                endcase
            end
            OP_LW: begin
                o_cad          = RAW'(w_rt);
                o_ctrl.af      = AF_ADD;
                o_ctrl.immSext = 1'b1;
                o_ctrl.aluBImm = 1'b1;
                o_ctrl.gpWe    = 1'b1;
                o_ctrl.gpMux   = GP_MUX_DM;
            end
            OP_SW: begin
                o_ctrl.af      = AF_ADD;
                o_ctrl.immSext = 1'b1;
                o_ctrl.aluBImm = 1'b1;
                o_ctrl.dmWe    = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            o_ctrl = CTRL_NOP;
            o_cad  = '0;
        end
    end

endmodule

// File: rtl/dec_pipe_stage.sv
// Registered, valid/ready handshaked decode stage with load-use interlock,
// r0-write suppression and saturating delivered/illegal bundle counters.
module dec_pipe_stage
    import dec_pkg::*;
#(
    parameter int RAW       = 5,
    parameter int LINK_REG  = 31,
    parameter int CNTW      = 16,
    parameter int HAZARD_EN = 1,
    parameter int R0_SUPPR  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      af,
    output logic            i,
    output logic            ALU_MUX_SEL,
    output logic [RAW-1:0]  cad,
    output logic            GP_WE,
    output logic [1:0]      GP_MUX_SEL,
    output logic [3:0]      bf,
    output logic            DM_WE,
    output logic [2:0]      Shift_type,
    output logic [1:0]      PC_MUX_SEL,
    output logic            out_illegal,
    output logic [CNTW-1:0] dec_cnt,
    output logic [CNTW-1:0] err_cnt
);

    ctrl_t          w_ctrl;
    ctrl_t          w_ctrlSup;
    logic [RAW-1:0] w_cad;
    logic           w_illegal;
    logic           w_readsRt;
    logic           w_isLoad;
    logic [RAW-1:0] w_rs;
    logic [RAW-1:0] w_rt;
    logic           w_stall;
    logic           w_fireIn;
    logic           w_fireOut;
    hz_state_t      w_hzNext;

    ctrl_t          r_ctrl;
    logic [RAW-1:0] r_cad;
    logic           r_illegal;
    logic           r_outValid;
    logic [CNTW-1:0] r_decCnt;
    logic [CNTW-1:0] r_errCnt;
    hz_state_t      r_hzState;
    logic [RAW-1:0] r_ldRd;

    dec_core #(
        .RAW      (RAW),
        .LINK_REG (LINK_REG)
    ) u_core (
        .i_instruction (instruction),
        .o_ctrl        (w_ctrl),
        .o_cad         (w_cad),
        .o_illegal     (w_illegal),
        .o_readsRt     (w_readsRt),
        .o_isLoad      (w_isLoad)
    );

    assign w_rs = RAW'(instruction[25:21]);
    assign w_rt = RAW'(instruction[20:16]);

    // A dependent consumer may not enter while the producing LW still sits in the output register.
    assign w_stall = (HAZARD_EN != 0) && (r_hzState == HZ_LD_OUT) && in_valid &&
                     (r_ldRd != '0) &&
                     ((w_rs == r_ldRd) || (w_readsRt && (w_rt == r_ldRd)));

    assign in_ready  = (~r_outValid | out_ready) & ~w_stall;
    assign w_fireIn  = in_valid && in_ready;
    assign w_fireOut = r_outValid && out_ready;

    always_comb begin
        w_ctrlSup = w_ctrl;
        if ((R0_SUPPR != 0) && (w_cad == '0)) begin
            w_ctrlSup.gpWe = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_ctrl     <= CTRL_NOP;
            r_cad      <= '0;
            r_illegal  <= 1'b0;
        end else if (w_fireIn) begin
            r_outValid <= 1'b1;
            r_ctrl     <= w_ctrlSup;
            r_cad      <= w_cad;
            r_illegal  <= w_illegal;
        end else if (w_fireOut) begin
            r_outValid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_decCnt <= '0;
            r_errCnt <= '0;
        end else if (w_fireOut) begin
            if (r_decCnt != '1) begin
                r_decCnt <= r_decCnt + CNTW'(1);
            end
            if (r_illegal && (r_errCnt != '1)) begin
                r_errCnt <= r_errCnt + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hzState <= HZ_IDLE;
            r_ldRd    <= '0;
        end else begin
            r_hzState <= w_hzNext;
            if (w_fireIn && w_isLoad) begin
                r_ldRd <= w_rt;
            end
        end
    end

    // LD_GAP is the one-cycle tail after the LW leaves, before returning to IDLE.
    always_comb begin
        w_hzNext = r_hzState;
        if (w_fireIn && w_isLoad) begin
            w_hzNext = HZ_LD_OUT;
        end else begin
            case (r_hzState)
                HZ_LD_OUT: if (w_fireOut) w_hzNext = HZ_LD_GAP;
                HZ_LD_GAP: w_hzNext = HZ_IDLE;
                default:   w_hzNext = HZ_IDLE;
            endcase
        end
    end

    assign out_valid   = r_outValid;
    assign af          = r_ctrl.af;
    assign i           = r_ctrl.immSext;
    assign ALU_MUX_SEL = r_ctrl.aluBImm;
    assign cad         = r_cad;
    assign GP_WE       = r_ctrl.gpWe;
    assign GP_MUX_SEL  = r_ctrl.gpMux;
    assign bf          = r_ctrl.bf;
    assign DM_WE       = r_ctrl.dmWe;
    assign Shift_type  = r_ctrl.shift;
    assign PC_MUX_SEL  = r_ctrl.pcMux;
    assign out_illegal = r_illegal;
    assign dec_cnt     = r_decCnt;
    assign err_cnt     = r_errCnt;

endmodule

// File: tb/tb_dec_pipe_stage.sv
// Directed self-checking bench for dec_pipe_stage: default instance plus a
// no-interlock instance with 3-bit counters for the bypass and saturation cases.
module tb_dec_pipe_stage;

    localparam logic [31:0] LW_R5   = 32'h8C850004;
    localparam logic [31:0] ADD_DEP = 32'h00A43020;
    localparam logic [31:0] ADD_IND = 32'h00C73020;
    localparam logic [31:0] SW_R5   = 32'hAC850004;
    localparam logic [31:0] ILL_3F  = 32'hFC000000;
    localparam logic [31:0] JAL_9   = 32'h0C000009;
    localparam logic [31:0] ADD_R0  = 32'h00A40020;
    localparam logic [31:0] BEQ_45  = 32'h10850003;

    logic        clk;
    logic        rst_n;
    logic        inValid;
    logic        inReady;
    logic [31:0] instr;
    logic        outValid;
    logic        outReady;
    logic [3:0]  af;
    logic        iSext;
    logic        aluMuxSel;
    logic [4:0]  cad;
    logic        gpWe;
    logic [1:0]  gpMuxSel;
    logic [3:0]  bf;
    logic        dmWe;
    logic [2:0]  shiftType;
    logic [1:0]  pcMuxSel;
    logic        outIllegal;
    logic [15:0] decCnt;
    logic [15:0] errCnt;

    logic        inValid2;
    logic        inReady2;
    logic [31:0] instr2;
    logic        outValid2;
    logic        outReady2;
    logic [3:0]  af2;
    logic        iSext2;
    logic        aluMuxSel2;
    logic [4:0]  cad2;
    logic        gpWe2;
    logic [1:0]  gpMuxSel2;
    logic [3:0]  bf2;
    logic        dmWe2;
    logic [2:0]  shiftType2;
    logic [1:0]  pcMuxSel2;
    logic        outIllegal2;
    logic [2:0]  decCnt2;
    logic [2:0]  errCnt2;

    int checks = 0;
    int passes = 0;

    dec_pipe_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid), .in_ready(inReady), .instruction(instr),
        .out_valid(outValid), .out_ready(outReady),
        .af(af), .i(iSext), .ALU_MUX_SEL(aluMuxSel), .cad(cad), .GP_WE(gpWe),
        .GP_MUX_SEL(gpMuxSel), .bf(bf), .DM_WE(dmWe), .Shift_type(shiftType),
        .PC_MUX_SEL(pcMuxSel), .out_illegal(outIllegal),
        .dec_cnt(decCnt), .err_cnt(errCnt)
    );

    dec_pipe_stage #(.HAZARD_EN(0), .CNTW(3)) dutNoHaz (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid2), .in_ready(inReady2), .instruction(instr2),
        .out_valid(outValid2), .out_ready(outReady2),
        .af(af2), .i(iSext2), .ALU_MUX_SEL(aluMuxSel2), .cad(cad2), .GP_WE(gpWe2),
        .GP_MUX_SEL(gpMuxSel2), .bf(bf2), .DM_WE(dmWe2), .Shift_type(shiftType2),
        .PC_MUX_SEL(pcMuxSel2), .out_illegal(outIllegal2),
        .dec_cnt(decCnt2), .err_cnt(errCnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] w, input logic r);
        inValid  = v;
        instr    = w;
        outReady = r;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0);
        inValid2 = 1'b0; instr2 = 32'h0; outReady2 = 1'b0;
        repeat (2) tick();
        checkOutput("rst_out_valid", outValid, 0);
        checkOutput("rst_dec_cnt", decCnt, 0);
        checkOutput("rst_err_cnt", errCnt, 0);
        checkOutput("rst_gp_we", gpWe, 0);
        checkOutput("rst_cad", cad, 0);
        checkOutput("rst_illegal", outIllegal, 0);
        checkOutput("rst_in_ready", inReady, 1);
        rst_n = 1'b1;
        tick();

        // LW alone
        applyStimulus(1'b1, LW_R5, 1'b1);
        tick();
        inValid = 1'b0;
        checkOutput("lw_valid", outValid, 1);
        checkOutput("lw_cad", cad, 5);
        checkOutput("lw_gp_we", gpWe, 1);
        checkOutput("lw_gp_mux", gpMuxSel, 2'b01);
        checkOutput("lw_alu_mux", aluMuxSel, 1);
        checkOutput("lw_dm_we", dmWe, 0);
        checkOutput("lw_sext", iSext, 1);
        tick();
        checkOutput("lw_dec_cnt", decCnt, 1);
        checkOutput("lw_drained", outValid, 0);
        tick();

        // LW then dependent ADD: one bubble
        applyStimulus(1'b1, LW_R5, 1'b1);
        #1 checkOutput("dep_lw_ready", inReady, 1);
        tick();
        instr = ADD_DEP;
        #1 checkOutput("dep_stall", inReady, 0);
        tick();
        checkOutput("dep_bubble", outValid, 0);
        checkOutput("dep_ready_again", inReady, 1);
        checkOutput("dep_cnt_lw", decCnt, 2);
        tick();
        inValid = 1'b0;
        checkOutput("dep_add_valid", outValid, 1);
        checkOutput("dep_add_cad", cad, 6);
        checkOutput("dep_add_we", gpWe, 1);
        checkOutput("dep_add_gp_mux", gpMuxSel, 2'b00);
        tick();
        checkOutput("dep_cnt_add", decCnt, 3);

        // LW then independent ADD: back-to-back
        applyStimulus(1'b1, LW_R5, 1'b1);
        tick();
        instr = ADD_IND;
        #1 checkOutput("ind_no_stall", inReady, 1);
        tick();
        inValid = 1'b0;
        checkOutput("ind_valid", outValid, 1);
        checkOutput("ind_cad", cad, 6);
        checkOutput("ind_alu_mux", aluMuxSel, 0);
        tick();
        checkOutput("ind_cnt", decCnt, 5);

        // SW held under backpressure
        applyStimulus(1'b1, SW_R5, 1'b0);
        tick();
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_valid", outValid, 1);
            checkOutput("bp_dm_we", dmWe, 1);
            checkOutput("bp_gp_we", gpWe, 0);
            checkOutput("bp_in_ready", inReady, 0);
            checkOutput("bp_cnt", decCnt, 5);
            tick();
        end
        outReady = 1'b1;
        #1 checkOutput("bp_release_ready", inReady, 1);
        tick();
        inValid = 1'b0;
        checkOutput("bp_release_cnt", decCnt, 6);
        tick();
        checkOutput("bp_final_cnt", decCnt, 7);

        // Illegal, JAL, r0 suppression, BEQ streamed
        applyStimulus(1'b1, ILL_3F, 1'b1);
        tick();
        checkOutput("ill_flag", outIllegal, 1);
        checkOutput("ill_gp_we", gpWe, 0);
        checkOutput("ill_dm_we", dmWe, 0);
        checkOutput("ill_pc_mux", pcMuxSel, 0);
        checkOutput("ill_cad", cad, 0);
        instr = JAL_9;
        tick();
        checkOutput("ill_err_cnt", errCnt, 1);
        checkOutput("jal_cnt", decCnt, 8);
        checkOutput("jal_cad", cad, 31);
        checkOutput("jal_gp_mux", gpMuxSel, 2'b10);
        checkOutput("jal_pc_mux", pcMuxSel, 2'b10);
        checkOutput("jal_gp_we", gpWe, 1);
        checkOutput("jal_legal", outIllegal, 0);
        instr = ADD_R0;
        tick();
        checkOutput("r0_cnt", decCnt, 9);
        checkOutput("r0_err_cnt", errCnt, 1);
        checkOutput("r0_gp_we", gpWe, 0);
        checkOutput("r0_cad", cad, 0);
        checkOutput("r0_valid", outValid, 1);
        instr = BEQ_45;
        tick();
        inValid = 1'b0;
        checkOutput("beq_bf", bf, 1);
        checkOutput("beq_pc_mux", pcMuxSel, 2'b01);
        checkOutput("beq_gp_we", gpWe, 0);
        tick();
        checkOutput("beq_cnt", decCnt, 11);

        // Reset while stalled, then interlock again from a clean state
        applyStimulus(1'b1, LW_R5, 1'b0);
        tick();
        instr = ADD_DEP;
        tick();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", outValid, 0);
        checkOutput("midrst_dec_cnt", decCnt, 0);
        checkOutput("midrst_err_cnt", errCnt, 0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        applyStimulus(1'b1, LW_R5, 1'b1);
        tick();
        instr = ADD_DEP;
        #1 checkOutput("post_stall", inReady, 0);
        tick();
        checkOutput("post_bubble", outValid, 0);
        tick();
        inValid = 1'b0;
        checkOutput("post_add_cad", cad, 6);
        checkOutput("post_add_valid", outValid, 1);
        tick();
        checkOutput("post_cnt", decCnt, 2);

        // No interlock, narrow counter saturation
        inValid2 = 1'b1; instr2 = LW_R5; outReady2 = 1'b1;
        tick();
        instr2 = ADD_DEP;
        #1 checkOutput("nohaz_ready", inReady2, 1);
        tick();
        checkOutput("nohaz_add_valid", outValid2, 1);
        checkOutput("nohaz_add_cad", cad2, 6);
        checkOutput("nohaz_add_we", gpWe2, 1);
        repeat (8) tick();
        inValid2 = 1'b0;
        checkOutput("sat_dec_cnt", decCnt2, 7);
        checkOutput("sat_err_cnt", errCnt2, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
